debug_frame_collector: RTL and testbench

//  Initiator side of the debug request/frame protocol. Takes a command byte

---
 rtl/debug_frame_collector.sv | 193 +++++++++++++++++++
 tb/tb_debug_frame_collector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_collector.sv
// rtl/debug_frame_collector.sv - debug request initiator: selects a controller, captures its frames, streams them to UART TX
module debug_frame_collector #(
  parameter int                    NB_CONTROL_FRAME = 32,
  parameter int                    NB_REQUEST       = 6,
  parameter int                    NB_BYTE          = 8,
  parameter int                    MAX_FRAMES       = 4,
  parameter int                    TIMEOUT          = 16,
  parameter logic [NB_REQUEST-1:0] NO_REQUEST_ID    = '1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_cmd_valid,
  input  logic [NB_BYTE-1:0]          i_cmd,
  output logic [NB_REQUEST-1:0]       o_request_select,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_controller,
  input  logic                        i_writing,
  output logic [NB_BYTE-1:0]          o_tx_data,
  output logic                        o_tx_start,
  input  logic                        i_tx_done,
  output logic                        o_busy
);

  localparam int BYTES_PER_FRAME = NB_CONTROL_FRAME / NB_BYTE;
  localparam int NB_COUNT = $clog2(MAX_FRAMES + 1);
  localparam int NB_FIDX  = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int NB_BSEL  = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
  localparam int NB_INDEX = $clog2(1 + MAX_FRAMES * BYTES_PER_FRAME + 1);
  localparam int NB_TIMER = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(TIMEOUT - 1);
  localparam logic [NB_COUNT-1:0] COUNT_MAX  = NB_COUNT'(MAX_FRAMES);
  localparam logic [NB_BSEL-1:0]  BSEL_LAST  = NB_BSEL'(BYTES_PER_FRAME - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    CAPTURE,
    SEND,
    WAIT_TX
  } state_t;

  state_t                state, state_next;
  logic [NB_REQUEST-1:0] select_next;
  logic [NB_BYTE-1:0]    tx_data_next;
  logic                  tx_start_next;
  logic                  busy_next;
  logic [NB_COUNT-1:0]   frame_count, frame_count_next;
  logic [NB_TIMER-1:0]   timer, timer_next;
  logic [NB_INDEX-1:0]   byte_index, byte_index_next;
  logic [NB_INDEX-1:0]   last_index;
  logic [NB_FIDX-1:0]    frame_sel, frame_sel_next;
  logic [NB_BSEL-1:0]    byte_sel, byte_sel_next;
  logic                  capture_en;
  logic [NB_CONTROL_FRAME-1:0] frame_buf [MAX_FRAMES];
  logic [NB_CONTROL_FRAME-1:0] frame_word;
  logic [NB_BYTE-1:0]    current_byte;

  // Upper command bits carry no meaning for this block.
  logic unused_cmd;
  assign unused_cmd = ^i_cmd;

  // Byte currently addressed by the send pointer: header first, then frames MSB byte first.
  always_comb begin
    frame_word   = frame_buf[frame_sel];
    current_byte = '0;
    if (byte_index == '0) begin
      current_byte = NB_BYTE'(frame_count);
    end else begin
      for (int b = 0; b < BYTES_PER_FRAME; b++) begin
        if (byte_sel == NB_BSEL'(b)) begin
          current_byte = frame_word[NB_CONTROL_FRAME-1-b*NB_BYTE -: NB_BYTE];
        end
      end
    end
    last_index = NB_INDEX'(int'(frame_count) * BYTES_PER_FRAME);
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_next       = state;
    select_next      = o_request_select;
    tx_data_next     = o_tx_data;
    tx_start_next    = 1'b0;
    frame_count_next = frame_count;
    timer_next       = timer;
    byte_index_next  = byte_index;
    frame_sel_next   = frame_sel;
    byte_sel_next    = byte_sel;
    capture_en       = 1'b0;

    case (state)
      IDLE: begin
        if (i_cmd_valid && (i_cmd[NB_REQUEST-1:0] != NO_REQUEST_ID)) begin
          state_next  = REQUEST;
          select_next = i_cmd[NB_REQUEST-1:0];
          timer_next  = '0;
        end
      end
      REQUEST: begin
        // A frame on the timeout cycle still counts as a response.
        if (i_writing) begin
          capture_en       = 1'b1;
          frame_count_next = NB_COUNT'(1);
          state_next       = CAPTURE;
        end else if (timer == TIMER_LAST) begin
          frame_count_next = '0;
          state_next       = SEND;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      CAPTURE: begin
        if (i_writing && (frame_count < COUNT_MAX)) begin
          capture_en       = 1'b1;
          frame_count_next = frame_count + 1'b1;
        end
        if (!i_writing || (frame_count_next == COUNT_MAX)) begin
          state_next = SEND;
        end
      end
      SEND: begin
        tx_data_next  = current_byte;
        tx_start_next = 1'b1;
        state_next    = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_index == last_index) begin
            state_next       = IDLE;
            frame_count_next = '0;
            byte_index_next  = '0;
            frame_sel_next   = '0;
            byte_sel_next    = '0;
          end else begin
            state_next      = SEND;
            byte_index_next = byte_index + 1'b1;
            // The header does not consume a frame byte.
            if (byte_index != '0) begin
              if (byte_sel == BSEL_LAST) begin
                byte_sel_next  = '0;
                frame_sel_next = frame_sel + 1'b1;
              end else begin
                byte_sel_next = byte_sel + 1'b1;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Drop the select on the same edge that leaves the request phase.
    if ((state_next != REQUEST) && (state_next != CAPTURE)) begin
      select_next = NO_REQUEST_ID;
    end
    busy_next = (state_next != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= IDLE;
      o_request_select <= NO_REQUEST_ID;
      o_tx_data        <= '0;
      o_tx_start       <= 1'b0;
      o_busy           <= 1'b0;
      frame_count      <= '0;
      timer            <= '0;
      byte_index       <= '0;
      frame_sel        <= '0;
      byte_sel         <= '0;
    end else begin
      state            <= state_next;
      o_request_select <= select_next;
      o_tx_data        <= tx_data_next;
      o_tx_start       <= tx_start_next;
      o_busy           <= busy_next;
      frame_count      <= frame_count_next;
      timer            <= timer_next;
      byte_index       <= byte_index_next;
      frame_sel        <= frame_sel_next;
      byte_sel         <= byte_sel_next;
    end
  end

  // Frame storage; contents only matter once frame_count says so, so no reset is needed.
  always_ff @(posedge i_clock) begin
    if (capture_en) begin
      frame_buf[frame_count[NB_FIDX-1:0]] <= i_frame_from_controller;
    end
  end

endmodule

// File: tb/tb_debug_frame_collector.sv
// tb/tb_debug_frame_collector.sv - scoreboard bench for debug_frame_collector
module tb_debug_frame_collector;

  logic        i_clock;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [7:0]  i_cmd;
  logic [5:0]  o_request_select;
  logic [31:0] i_frame_from_controller;
  logic        i_writing;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int unstable = 0;
  int tx_delay = 0;
  bit resp_busy = 0;
  logic [7:0] exp_q [$];

  debug_frame_collector dut (
    .i_clock                (i_clock),
    .i_reset                (i_reset),
    .i_cmd_valid            (i_cmd_valid),
    .i_cmd                  (i_cmd),
    .o_request_select       (o_request_select),
    .i_frame_from_controller(i_frame_from_controller),
    .i_writing              (i_writing),
    .o_tx_data              (o_tx_data),
    .o_tx_start             (o_tx_start),
    .i_tx_done              (i_tx_done),
    .o_busy                 (o_busy)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] f);
    for (int b = 3; b >= 0; b--) exp_q.push_back(f[b*8 +: 8]);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    i_cmd = c;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((o_busy || resp_busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle_in_time"}, 32'(n < budget), 1);
    check({tag, "_all_bytes_seen"}, exp_q.size(), 0);
    check({tag, "_select_idle"}, o_request_select, 6'h3f);
  endtask

  // UART TX model: pops the scoreboard on each start strobe, answers with tx_done after tx_delay cycles.
  initial begin
    logic [7:0] held;
    i_tx_done = 1'b0;
    forever begin
      @(posedge i_clock);
      #1;
      if (o_tx_start) begin
        start_cnt++;
        resp_busy = 1'b1;
        if (exp_q.size() == 0) check("tx_unexpected_start", 1, 0);
        else check("tx_byte", o_tx_data, exp_q.pop_front());
        held = o_tx_data;
        for (int i = 0; i < tx_delay; i++) begin
          tick();
          if (o_busy && (o_tx_data !== held)) unstable++;
          if (o_tx_start) begin
            start_cnt++;
            check("tx_start_while_waiting", 1, 0);
          end
        end
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int bad;
    i_reset = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd = '0;
    i_writing = 1'b0;
    i_frame_from_controller = '0;
    repeat (3) tick();
    check("rst_select", o_request_select, 6'h3f);
    check("rst_busy", o_busy, 0);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_data", o_tx_data, 0);
    i_reset = 1'b0;
    tick();

    // Single frame response.
    exp_q.push_back(8'h01);
    push_frame(32'hDEADBEEF);
    base = start_cnt;
    send_cmd(8'h03);
    check("t1_select_req", o_request_select, 6'h03);
    check("t1_busy", o_busy, 1);
    i_writing = 1'b1;
    i_frame_from_controller = 32'hDEADBEEF;
    tick();
    check("t1_select_capture", o_request_select, 6'h03);
    i_writing = 1'b0;
    tick();
    check("t1_select_released", o_request_select, 6'h3f);
    check("t1_busy_send", o_busy, 1);
    wait_idle("t1", 500);
    check("t1_strobes", start_cnt - base, 5);
    check("t1_busy_end", o_busy, 0);

    // Six frames offered, only MAX_FRAMES kept.
    exp_q.push_back(8'h04);
    for (int f = 1; f <= 4; f++) push_frame(32'(f) * 32'h11111111);
    base = start_cnt;
    send_cmd(8'h05);
    check("t2_select", o_request_select, 6'h05);
    for (int f = 1; f <= 6; f++) begin
      i_writing = 1'b1;
      i_frame_from_controller = 32'(f) * 32'h11111111;
      tick();
    end
    i_writing = 1'b0;
    wait_idle("t2", 1000);
    check("t2_strobes", start_cnt - base, 17);

    // No response: timeout after TIMEOUT cycles, header only.
    exp_q.push_back(8'h00);
    base = start_cnt;
    send_cmd(8'h07);
    n = 0;
    while (o_request_select == 6'h07 && n < 40) begin
      n++;
      tick();
    end
    check("t3_request_cycles", n, 16);
    wait_idle("t3", 200);
    check("t3_strobes", start_cnt - base, 1);

    // Response on the timeout cycle is captured.
    exp_q.push_back(8'h01);
    push_frame(32'hA5C3_0F1E);
    base = start_cnt;
    send_cmd(8'h0A);
    repeat (15) tick();
    check("t7_still_requesting", o_request_select, 6'h0A);
    i_writing = 1'b1;
    i_frame_from_controller = 32'hA5C3_0F1E;
    tick();
    i_writing = 1'b0;
    wait_idle("t7", 500);
    check("t7_strobes", start_cnt - base, 5);

    // Idle ID ignored; commands during a transfer dropped.
    send_cmd(8'h3F);
    check("t4_idle_cmd_busy", o_busy, 0);
    tick();
    check("t4_idle_cmd_select", o_request_select, 6'h3f);
    tx_delay = 5;
    exp_q.push_back(8'h01);
    push_frame(32'h0102_0304);
    base = start_cnt;
    send_cmd(8'h02);
    i_writing = 1'b1;
    i_frame_from_controller = 32'h0102_0304;
    tick();
    i_writing = 1'b0;
    tick();
    n = 0;
    bad = 0;
    while ((o_busy || resp_busy) && n < 500) begin
      if (o_request_select != 6'h3f) bad++;
      if (o_busy && (n % 3 == 0)) begin
        i_cmd = 8'h09;
        i_cmd_valid = 1'b1;
      end
      tick();
      i_cmd_valid = 1'b0;
      n++;
    end
    check("t4_done_in_time", 32'(n < 500), 1);
    check("t4_select_during_send", bad, 0);
    check("t4_strobes", start_cnt - base, 5);
    check("t4_queue_empty", exp_q.size(), 0);
    repeat (3) tick();
    check("t4_no_queued_cmd_busy", o_busy, 0);
    check("t4_no_queued_cmd_select", o_request_select, 6'h3f);

    // Reset in the middle of a transfer.
    tx_delay = 10;
    exp_q.push_back(8'h01);
    push_frame(32'hCAFEF00D);
    base = start_cnt;
    send_cmd(8'h04);
    i_writing = 1'b1;
    i_frame_from_controller = 32'hCAFEF00D;
    tick();
    i_writing = 1'b0;
    n = 0;
    while (start_cnt < base + 3 && n < 500) begin
      tick();
      n++;
    end
    check("t5_reached_byte2", 32'(n < 500), 1);
    tick();
    i_reset = 1'b1;
    tick();
    check("t5_rst_select", o_request_select, 6'h3f);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_tx_start", o_tx_start, 0);
    check("t5_rst_tx_data", o_tx_data, 0);
    i_reset = 1'b0;
    exp_q.delete();
    base = start_cnt;
    repeat (30) tick();
    check("t5_no_strobe_after_reset", start_cnt - base, 0);
    check("t5_responder_idle", resp_busy, 0);
    tx_delay = 0;
    exp_q.push_back(8'h01);
    push_frame(32'h0BADC0DE);
    base = start_cnt;
    send_cmd(8'h01);
    check("t5_new_select", o_request_select, 6'h01);
    i_writing = 1'b1;
    i_frame_from_controller = 32'h0BADC0DE;
    tick();
    i_writing = 1'b0;
    wait_idle("t5", 500);
    check("t5_strobes", start_cnt - base, 5);

    // Slow UART: data held, one strobe per byte.
    tx_delay = 100;
    unstable = 0;
    exp_q.push_back(8'h01);
    push_frame(32'h12345678);
    base = start_cnt;
    send_cmd(8'h02);
    i_writing = 1'b1;
    i_frame_from_controller = 32'h12345678;
    tick();
    i_writing = 1'b0;
    wait_idle("t6", 2000);
    check("t6_strobes", start_cnt - base, 5);
    check("t6_tx_data_stable", unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
